// File: rtl/div_pkg.sv
// Package: div_pkg
// Shared types and helpers for the restoring divider.
//   div_state_t : FSM state encoding (IDLE, DIVIDE, DONE)
//   cnt_w()     : width of the step counter for a given operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } div_state_t;

    // The counter runs WIDTH-1 down to 0.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage : div_pkg

// File: rtl/sub_stage.sv
// Module: sub_stage
// Combinational N-bit subtractor a - b, built as a + ~b + 1 on a
// generate/propagate carry chain (the same structure as the 4-bit adder).
// Ports:
//   a      in  N  minuend
//   b      in  N  subtrahend
//   diff   out N  a - b (modulo 2^N)
//   borrow out 1  high when a < b (unsigned)
module sub_stage #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N:0]   c;

    assign p = a ^ ~b;
    assign g = a & ~b;

    // c[0] = 1 supplies the +1 of the two's-complement negation.
    always_comb begin
        c[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign diff   = p ^ c[N-1:0];
    // A missing carry out of the top bit means the subtraction wrapped.
    assign borrow = ~c[N];

endmodule : sub_stage

// File: rtl/restoring_divider.sv
// Module: restoring_divider
// Multi-cycle unsigned restoring divider: one trial subtraction per cycle,
// driven by a start/done handshake. One result every WIDTH+1 cycles.
// Optional macro DIV_ZERO_EN: a zero divisor finishes in one edge and
// raises div_zero; without it div_zero is tied low and a zero divisor runs
// the full loop (quotient all ones, remainder = dividend).
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      asynchronous, active-high reset
//   start     in  1      request, accepted in IDLE or DONE
//   dividend  in  WIDTH  unsigned dividend, sampled on accepted start
//   divisor   in  WIDTH  unsigned divisor, sampled on accepted start
//   busy      out 1      high while dividing
//   done      out 1      one-cycle pulse, results valid
//   quotient  out WIDTH  result quotient, updated on entry to DONE
//   remainder out WIDTH  result remainder, updated on entry to DONE
//   div_zero  out 1      divide-by-zero flag
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    div_state_t       state_q;
    div_state_t       state_d;
    logic [WIDTH:0]   r_q;        // partial remainder, one guard bit
    logic [WIDTH-1:0] q_q;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] divisor_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             zero_fast;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;

    assign accept = start && (state_q == IDLE || state_q == DONE);

`ifdef DIV_ZERO_EN
    assign zero_fast = (divisor == '0);
`else
    assign zero_fast = 1'b0;
`endif

    // Datapath for one restoring step.
    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    sub_stage #(
        .N (WIDTH + 1)
    ) u_sub (
        .a      (r_shift),
        .b      ({1'b0, divisor_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    // On borrow the shifted value is kept, which is the "restore".
    assign step_r = borrow ? r_shift : diff;
    assign step_q = {q_q[WIDTH-2:0], ~borrow};

    assign busy = (state_q == DIVIDE);
    assign done = (state_q == DONE);

    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = zero_fast ? DONE : DIVIDE;
                end else begin
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every datapath register is reset, including the working R/Q,
    // so an abort mid-divide leaves no stale state visible anywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            q_q       <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            r_q       <= '0;
            q_q       <= dividend;
            divisor_q <= divisor;
            cnt_q     <= CNT_MAX;
            div_zero  <= 1'b0;
            if (zero_fast) begin
                quotient  <= '1;
                remainder <= dividend;
                div_zero  <= 1'b1;
            end
        end else if (state_q == DIVIDE) begin
            r_q <= step_r;
            q_q <= step_q;
            if (cnt_q == '0) begin
                // Results are captured from the final step, entering DONE.
                quotient  <= step_q;
                remainder <= step_r[WIDTH-1:0];
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule : restoring_divider

// File: tb/tb_restoring_divider.sv
// Testbench for restoring_divider (WIDTH=4): directed vectors with
// hand-computed results, abort/back-to-back handshake scenarios and a
// sweep over all dividend x nonzero-divisor pairs.
`timescale 1ns/1ps
module tb_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int errors = 0;
    int checks = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on falling edges.
    // Waits until done; edges counts rising edges from (and including)
    // the one that samples start; busy_cnt counts sampled busy cycles.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 1;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            edges++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL timeout: done=%b after %0d edges, required 1", done, edges);
        end
    endtask

    task automatic run_div(input logic [W-1:0] dv, input logic [W-1:0] ds,
                           output int edges, output int busy_cnt);
        @(negedge clk);
        start    = 1'b1;
        dividend = dv;
        divisor  = ds;
        @(negedge clk);
        start    = 1'b0;
        dividend = 'x;
        divisor  = 'x;
        wait_done(edges, busy_cnt);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (quotient !== 4'd0)  begin errors++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
        if (remainder !== 4'd0) begin errors++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
        if (div_zero !== 1'b0)  begin errors++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int e, b;
        // 13 / 3 = 4 rem 1, done 5 edges after start, busy 4 cycles.
        run_div(4'd13, 4'd3, e, b);
        checks += 5;
        if (e !== 5)            begin errors++; $display("FAIL lat_13_3: got %0d edges want 5", e); end
        if (b !== 4)            begin errors++; $display("FAIL busy_13_3: got %0d cycles want 4", b); end
        if (quotient !== 4'd4)  begin errors++; $display("FAIL q_13_3: got %0d want 4", quotient); end
        if (remainder !== 4'd1) begin errors++; $display("FAIL r_13_3: got %0d want 1", remainder); end
        if (div_zero !== 1'b0)  begin errors++; $display("FAIL dz_13_3: got %b want 0", div_zero); end
        // Results hold in IDLE and done drops after one cycle.
        repeat (3) @(negedge clk);
        checks += 3;
        if (done !== 1'b0)      begin errors++; $display("FAIL idle_done: got %b want 0", done); end
        if (quotient !== 4'd4)  begin errors++; $display("FAIL idle_q_hold: got %0d want 4", quotient); end
        if (remainder !== 4'd1) begin errors++; $display("FAIL idle_r_hold: got %0d want 1", remainder); end
        // 15 / 1 = 15 rem 0.
        run_div(4'd15, 4'd1, e, b);
        checks += 2;
        if (quotient !== 4'd15) begin errors++; $display("FAIL q_15_1: got %0d want 15", quotient); end
        if (remainder !== 4'd0) begin errors++; $display("FAIL r_15_1: got %0d want 0", remainder); end
        // 2 / 7 = 0 rem 2.
        run_div(4'd2, 4'd7, e, b);
        checks += 2;
        if (quotient !== 4'd0)  begin errors++; $display("FAIL q_2_7: got %0d want 0", quotient); end
        if (remainder !== 4'd2) begin errors++; $display("FAIL r_2_7: got %0d want 2", remainder); end
    endtask

    task automatic test_div_zero();
        int e, b;
        run_div(4'd9, 4'd0, e, b);
        checks += 4;
`ifdef DIV_ZERO_EN
        if (e !== 1)            begin errors++; $display("FAIL lat_div0: got %0d edges want 1", e); end
        if (div_zero !== 1'b1)  begin errors++; $display("FAIL dz_div0: got %b want 1", div_zero); end
`else
        if (e !== 5)            begin errors++; $display("FAIL lat_div0: got %0d edges want 5", e); end
        if (div_zero !== 1'b0)  begin errors++; $display("FAIL dz_div0: got %b want 0", div_zero); end
`endif
        if (quotient !== 4'd15) begin errors++; $display("FAIL q_div0: got %0d want 15", quotient); end
        if (remainder !== 4'd9) begin errors++; $display("FAIL r_div0: got %0d want 9", remainder); end
        // The flag clears on the next accepted start.
        run_div(4'd7, 4'd2, e, b);
        checks += 3;
        if (div_zero !== 1'b0)  begin errors++; $display("FAIL dz_clear: got %b want 0", div_zero); end
        if (quotient !== 4'd3)  begin errors++; $display("FAIL q_7_2: got %0d want 3", quotient); end
        if (remainder !== 4'd1) begin errors++; $display("FAIL r_7_2: got %0d want 1", remainder); end
    endtask

    task automatic test_back_to_back();
        int e, b;
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);                      // edge 1 accepted 13/3
        start = 1'b0;
        @(negedge clk);                      // edge 2, dividing
        start = 1'b1; dividend = 4'd8; divisor = 4'd2;
        @(negedge clk);                      // edge 3 must ignore 8/2
        start = 1'b0; dividend = 'x; divisor = 'x;
        // Two more edges have passed since the start edge.
        e = 3; b = 0;
        while (!done && e < 40) begin
            @(negedge clk);
            e++;
        end
        checks += 3;
        if (e !== 5)            begin errors++; $display("FAIL lat_ignore: got %0d edges want 5", e); end
        if (quotient !== 4'd4)  begin errors++; $display("FAIL q_ignore: got %0d want 4", quotient); end
        if (remainder !== 4'd1) begin errors++; $display("FAIL r_ignore: got %0d want 1", remainder); end
        // Start held high during the DONE cycle is accepted directly.
        start = 1'b1; dividend = 4'd8; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0; dividend = 'x; divisor = 'x;
        checks += 2;
        if (busy !== 1'b1)      begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL b2b_done: got %b want 0", done); end
        wait_done(e, b);
        checks += 3;
        if (e !== 5)            begin errors++; $display("FAIL lat_b2b: got %0d edges want 5", e); end
        if (quotient !== 4'd4)  begin errors++; $display("FAIL q_b2b: got %0d want 4", quotient); end
        if (remainder !== 4'd0) begin errors++; $display("FAIL r_b2b: got %0d want 0", remainder); end
    endtask

    task automatic test_async_reset();
        int e, b;
        // Leave a nonzero result so the reset clears something visible.
        run_div(4'd11, 4'd4, e, b);
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);                      // second cycle of the divide
        #2 rst = 1'b1;                       // between clock edges
        #1;
        checks += 4;
        if (busy !== 1'b0)      begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL arst_done: got %b want 0", done); end
        if (quotient !== 4'd0)  begin errors++; $display("FAIL arst_q: got %0d want 0", quotient); end
        if (remainder !== 4'd0) begin errors++; $display("FAIL arst_r: got %0d want 0", remainder); end
        @(negedge clk);
        rst = 1'b0;
        run_div(4'd6, 4'd4, e, b);
        checks += 3;
        if (e !== 5)            begin errors++; $display("FAIL lat_6_4: got %0d edges want 5", e); end
        if (quotient !== 4'd1)  begin errors++; $display("FAIL q_6_4: got %0d want 1", quotient); end
        if (remainder !== 4'd2) begin errors++; $display("FAIL r_6_4: got %0d want 2", remainder); end
    endtask

    task automatic test_sweep();
        int e, b;
        logic [W-1:0] exp_q, exp_r;
        for (int dv = 0; dv < (1 << W); dv++) begin
            for (int ds = 1; ds < (1 << W); ds++) begin
                exp_q = W'(dv / ds);
                exp_r = W'(dv % ds);
                run_div(W'(dv), W'(ds), e, b);
                checks += 3;
                if (quotient !== exp_q || remainder !== exp_r) begin
                    errors++;
                    $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d want q=%0d r=%0d",
                             dv, ds, quotient, remainder, exp_q, exp_r);
                end
                if (e !== W + 1) begin
                    errors++;
                    $display("FAIL sweep_lat_%0d_%0d: got %0d edges want %0d", dv, ds, e, W + 1);
                end
                @(negedge clk);
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_pulse_%0d_%0d: done=%b one cycle later, want 0", dv, ds, done);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_async_reset();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_restoring_divider
